// File: rtl/axi_stream_pkg.sv
// Shared types and byte-lane helpers for the AXI-Stream header insert/strip stages.
// Byte lane DATA_BYTE_WD-1 is the first byte on the wire (big-endian).
package axi_stream_pkg;

   localparam int DATA_WD      = 32;
   localparam int DATA_BYTE_WD = DATA_WD / 8;
   localparam int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);
   localparam int CNT_WD       = BYTE_CNT_WD + 1;

   typedef logic [DATA_WD-1:0]      data_t;
   typedef logic [DATA_BYTE_WD-1:0] keep_t;
   typedef logic [BYTE_CNT_WD-1:0]  bcnt_t;
   // Byte counts that must reach DATA_BYTE_WD inclusive.
   typedef logic [CNT_WD-1:0]       cnt_t;

   typedef enum logic [1:0] {
      IDLE,
      FIRST,
      STREAM,
      FLUSH
   } state_e;

   function automatic cnt_t popcount(keep_t k);
      cnt_t n;
      n = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         n = n + cnt_t'(k[i]);
      end
      return n;
   endfunction

   function automatic keep_t keep_from_cnt(cnt_t n);
      return ~({DATA_BYTE_WD{1'b1}} >> n);
   endfunction

   function automatic data_t expand_keep(keep_t k);
      data_t m;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         m[i*8 +: 8] = {8{k[i]}};
      end
      return m;
   endfunction

   function automatic data_t shl_bytes(data_t d, cnt_t n);
      return d << {n, 3'b000};
   endfunction

   function automatic data_t shr_bytes(data_t d, cnt_t n);
      return d >> {n, 3'b000};
   endfunction

   function automatic cnt_t min_cnt(cnt_t a, cnt_t b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_stream_strip_header_if.sv
// Bundle of the stream, strip-config and header handshakes of the strip stage.
// The slave modport is the stage itself; master is its environment.
interface axi_stream_strip_header_if;
   import axi_stream_pkg::*;

   logic  valid_in;
   data_t data_in;
   keep_t keep_in;
   logic  last_in;
   logic  ready_in;

   logic  valid_out;
   data_t data_out;
   keep_t keep_out;
   logic  last_out;
   logic  ready_out;

   logic  valid_strip;
   bcnt_t byte_strip_cnt;
   logic  ready_strip;

   logic  valid_hdr;
   data_t data_hdr;
   keep_t keep_hdr;
   logic  ready_hdr;

   modport slave (
      input  valid_in, data_in, keep_in, last_in,
      output ready_in,
      output valid_out, data_out, keep_out, last_out,
      input  ready_out,
      input  valid_strip, byte_strip_cnt,
      output ready_strip,
      output valid_hdr, data_hdr, keep_hdr,
      input  ready_hdr
   );

   modport master (
      output valid_in, data_in, keep_in, last_in,
      input  ready_in,
      input  valid_out, data_out, keep_out, last_out,
      output ready_out,
      output valid_strip, byte_strip_cnt,
      input  ready_strip,
      input  valid_hdr, data_hdr, keep_hdr,
      output ready_hdr
   );

endinterface

// File: rtl/axi_stream_out_reg.sv
// Single-entry output register with valid/ready handshake.
// Loads when empty or when its current beat drains in the same cycle.
module axi_stream_out_reg
   import axi_stream_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  data_t in_data,
   input  keep_t in_keep,
   input  logic  in_last,
   output logic  can_load,
   output logic  valid,
   output data_t data,
   output keep_t keep,
   output logic  last,
   input  logic  ready
);

   logic  valid_q, valid_d;
   data_t data_q, data_d;
   keep_t keep_q, keep_d;
   logic  last_q, last_d;

   assign can_load = !valid_q || ready;
   assign valid    = valid_q;
   assign data     = data_q;
   assign keep     = keep_q;
   assign last     = last_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = in_data;
         keep_d  = in_keep;
         last_d  = in_last;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
         data_d  = '0;
         keep_d  = '0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips H leading bytes per packet onto a header port and realigns
// the remaining payload so its first byte lands in the MSB lane.
module axi_stream_strip_header
   import axi_stream_pkg::*;
(
   input logic clk,
   input logic rst,
   axi_stream_strip_header_if.slave bus
);

   state_e state_q, state_d;
   cnt_t   strip_q, strip_d;
   data_t  hold_q, hold_d;
   cnt_t   hold_cnt_q, hold_cnt_d;

   logic   pay_load, pay_can, pay_last;
   data_t  pay_data;
   keep_t  pay_keep;
   logic   hdr_load, hdr_can;
   data_t  hdr_data;
   keep_t  hdr_keep;
   logic   hdr_last_unused;

   cnt_t   k;
   cnt_t   p;
   data_t  in_shl;
   data_t  in_shr;

   always_comb begin
      state_d    = state_q;
      strip_d    = strip_q;
      hold_d     = hold_q;
      hold_cnt_d = hold_cnt_q;
      bus.ready_in    = 1'b0;
      bus.ready_strip = 1'b0;
      pay_load = 1'b0;
      pay_data = '0;
      pay_keep = '0;
      pay_last = 1'b0;
      hdr_load = 1'b0;
      hdr_data = '0;
      hdr_keep = '0;
      k      = popcount(bus.keep_in);
      p      = cnt_t'(DATA_BYTE_WD) - strip_q;
      // Low lanes left behind after the header/S bytes are consumed.
      in_shl = shl_bytes(bus.data_in, strip_q);
      in_shr = shr_bytes(bus.data_in, p);
      unique case (state_q)
         IDLE: begin
            bus.ready_strip = !rst;
            if (bus.valid_strip && !rst) begin
               strip_d = cnt_t'(bus.byte_strip_cnt) + cnt_t'(1);
               state_d = FIRST;
            end
         end
         FIRST: begin
            bus.ready_in = !rst && hdr_can && pay_can;
            if (bus.ready_in && bus.valid_in) begin
               hdr_load   = 1'b1;
               hdr_keep   = keep_from_cnt(min_cnt(strip_q, k));
               hdr_data   = bus.data_in & expand_keep(hdr_keep);
               hold_d     = in_shl;
               hold_cnt_d = p;
               if (bus.last_in) begin
                  state_d = IDLE;
                  if (k > strip_q) begin
                     pay_load = 1'b1;
                     pay_keep = keep_from_cnt(k - strip_q);
                     pay_data = in_shl & expand_keep(pay_keep);
                     pay_last = 1'b1;
                  end
               end else begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            bus.ready_in = !rst && pay_can;
            if (bus.ready_in && bus.valid_in) begin
               pay_load   = 1'b1;
               hold_d     = in_shl;
               hold_cnt_d = p;
               if (bus.last_in && (k > strip_q)) begin
                  pay_keep   = '1;
                  hold_cnt_d = k - strip_q;
                  state_d    = FLUSH;
               end else begin
                  pay_keep = keep_from_cnt(p + min_cnt(strip_q, k));
                  pay_last = bus.last_in;
                  if (bus.last_in) state_d = IDLE;
               end
               pay_data = (hold_q | in_shr) & expand_keep(pay_keep);
            end
         end
         FLUSH: begin
            if (pay_can && !rst) begin
               pay_load = 1'b1;
               pay_keep = keep_from_cnt(hold_cnt_q);
               pay_data = hold_q & expand_keep(pay_keep);
               pay_last = 1'b1;
               state_d  = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         strip_q    <= '0;
         hold_q     <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         strip_q    <= strip_d;
         hold_q     <= hold_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   axi_stream_out_reg u_pay (
      .clk      (clk),
      .rst      (rst),
      .load     (pay_load),
      .in_data  (pay_data),
      .in_keep  (pay_keep),
      .in_last  (pay_last),
      .can_load (pay_can),
      .valid    (bus.valid_out),
      .data     (bus.data_out),
      .keep     (bus.keep_out),
      .last     (bus.last_out),
      .ready    (bus.ready_out)
   );

   axi_stream_out_reg u_hdr (
      .clk      (clk),
      .rst      (rst),
      .load     (hdr_load),
      .in_data  (hdr_data),
      .in_keep  (hdr_keep),
      .in_last  (1'b0),
      .can_load (hdr_can),
      .valid    (bus.valid_hdr),
      .data     (bus.data_hdr),
      .keep     (bus.keep_hdr),
      .last     (hdr_last_unused),
      .ready    (bus.ready_hdr)
   );

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench: packets are modelled as byte lists; expected header and
// payload beats are queued at issue time and popped by a monitor.
module tb_axi_stream_strip_header;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_stream_strip_header_if bus();

   axi_stream_strip_header dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_total = 0;
   int n_pass  = 0;
   beat_t pay_q[$];
   beat_t hdr_q[$];
   bit chk_en   = 1'b1;
   bit rand_rdy = 1'b0;
   bit hdr_stall = 1'b0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   task automatic note_fail(input string name);
      n_total++;
      $display("FAIL %s actual=timeout/unexpected required=event", name);
   endtask

   // Reference model: header = first min(H,len) bytes; payload = the rest,
   // cut into MSB-aligned 4-byte beats, last beat flagged.
   task automatic model(input int h, input bq_t pk);
      beat_t b;
      int n;
      n = (h < pk.size()) ? h : pk.size();
      b = '0;
      for (int i = 0; i < n; i++) begin
         b.d[31-8*i -: 8] = pk[i];
         b.k[3-i] = 1'b1;
      end
      hdr_q.push_back(b);
      for (int off = h; off < pk.size(); off += 4) begin
         b = '0;
         for (int j = 0; j < 4 && off + j < pk.size(); j++) begin
            b.d[31-8*j -: 8] = pk[off+j];
            b.k[3-j] = 1'b1;
         end
         b.l = (off + 4 >= pk.size());
         pay_q.push_back(b);
      end
   endtask

   task automatic send_cfg(input int h);
      int w = 0;
      bus.valid_strip = 1'b1;
      bus.byte_strip_cnt = 2'(h - 1);
      @(negedge clk);
      while (!bus.ready_strip && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (!bus.ready_strip) note_fail("timeout_cfg");
      @(posedge clk); #1;
      bus.valid_strip = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                            input logic l);
      int w = 0;
      bus.valid_in = 1'b1;
      bus.data_in  = d;
      bus.keep_in  = k;
      bus.last_in  = l;
      @(negedge clk);
      while (!bus.ready_in && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (!bus.ready_in) note_fail("timeout_beat");
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      bus.data_in  = $urandom;
   endtask

   task automatic beat_of(input bq_t pk, input int b, output logic [31:0] d,
                          output logic [3:0] k, output logic l);
      d = $urandom;
      k = '0;
      for (int j = 0; j < 4; j++) begin
         if (4*b + j < pk.size()) begin
            d[31-8*j -: 8] = pk[4*b+j];
            k[3-j] = 1'b1;
         end
      end
      l = (4*b + 4 >= pk.size());
   endtask

   task automatic send_pkt(input int h, input bq_t pk, input bit gaps);
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      model(h, pk);
      send_cfg(h);
      for (int b = 0; 4*b < pk.size(); b++) begin
         if (gaps) repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #1;
         end
         beat_of(pk, b, d, k, l);
         send_beat(d, k, l);
      end
   endtask

   // Downstream ready drivers, changed just after the active edge.
   initial begin
      bus.ready_out = 1'b1;
      bus.ready_hdr = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.ready_out = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.ready_hdr = hdr_stall ? 1'b0 :
                         (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Monitor: pops expectations on every accepted beat, checks stall stability.
   beat_t p_hold, h_hold;
   bit p_stalled = 1'b0;
   bit h_stalled = 1'b0;
   always @(negedge clk) begin
      beat_t e, a;
      if (rst || !chk_en) begin
         p_stalled = 1'b0;
         h_stalled = 1'b0;
      end else begin
         a = '{bus.data_out, bus.keep_out, bus.last_out};
         if (p_stalled)
            check("pay_stable", {bus.valid_out, a}, {1'b1, p_hold});
         if (bus.valid_out && bus.ready_out) begin
            if (pay_q.size() == 0) note_fail("pay_unexpected");
            else begin
               e = pay_q.pop_front();
               check("pay_beat", a, e);
            end
         end
         p_stalled = bus.valid_out && !bus.ready_out;
         p_hold = a;
         a = '{bus.data_hdr, bus.keep_hdr, 1'b0};
         if (h_stalled)
            check("hdr_stable", {bus.valid_hdr, a}, {1'b1, h_hold});
         if (bus.valid_hdr && bus.ready_hdr) begin
            if (hdr_q.size() == 0) note_fail("hdr_unexpected");
            else begin
               e = hdr_q.pop_front();
               check("hdr_beat", a, e);
            end
         end
         h_stalled = bus.valid_hdr && !bus.ready_hdr;
         h_hold = a;
      end
   end

   task automatic drain();
      int w = 0;
      while ((pay_q.size() != 0 || hdr_q.size() != 0) && w < 500) begin
         w++;
         @(posedge clk); #1;
      end
      check("drain_pay", 64'(pay_q.size()), 64'd0);
      check("drain_hdr", 64'(hdr_q.size()), 64'd0);
   endtask

   initial begin
      bq_t pk;
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      bus.valid_in = 1'b0;
      bus.data_in = '0;
      bus.keep_in = '0;
      bus.last_in = 1'b0;
      bus.valid_strip = 1'b0;
      bus.byte_strip_cnt = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outs", {bus.valid_out, bus.valid_hdr, bus.last_out,
            bus.ready_in, bus.ready_strip}, 64'd0);
      check("rst_data", {bus.data_out, bus.keep_out, bus.data_hdr,
            bus.keep_hdr}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready_strip", {bus.ready_strip, bus.ready_in}, 64'b10);
      @(posedge clk); #1;

      // Directed cases.
      pk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
      send_pkt(2, pk, 1'b0);
      pk = '{8'hAA, 8'hBB, 8'hCC};
      send_pkt(1, pk, 1'b0);
      pk = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06};
      send_pkt(4, pk, 1'b0);
      pk = '{8'hAA, 8'hBB, 8'hCC};
      send_pkt(3, pk, 1'b0);
      @(negedge clk);
      check("no_pay_ready_strip", {bus.ready_strip}, 64'd1);
      @(posedge clk); #1;
      drain();

      // Header stalled: STREAM continues, next FIRST waits.
      rand_rdy = 1'b1;
      hdr_stall = 1'b1;
      pk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
      send_pkt(2, pk, 1'b0);
      pk = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
      model(3, pk);
      send_cfg(3);
      beat_of(pk, 0, d, k, l);
      bus.valid_in = 1'b1;
      bus.data_in = d;
      bus.keep_in = k;
      bus.last_in = l;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("first_blocked", {bus.ready_in}, 64'd0);
      end
      @(posedge clk); #1;
      hdr_stall = 1'b0;
      send_beat(d, k, l);
      beat_of(pk, 1, d, k, l);
      send_beat(d, k, l);
      drain();

      // Reset mid-STREAM discards the packet.
      rand_rdy = 1'b0;
      chk_en = 1'b0;
      pk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'h09, 8'h0A, 8'h0B, 8'h0C};
      send_cfg(2);
      beat_of(pk, 0, d, k, l);
      send_beat(d, k, l);
      beat_of(pk, 1, d, k, l);
      send_beat(d, k, l);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst", {bus.valid_out, bus.valid_hdr, bus.ready_strip},
            64'b001);
      pay_q.delete();
      hdr_q.delete();
      chk_en = 1'b1;
      @(posedge clk); #1;
      pk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
      send_pkt(2, pk, 1'b0);
      drain();

      // Randomized packets under random backpressure.
      for (int n = 0; n < 60; n++) begin
         int h, len;
         rand_rdy = ($urandom_range(0, 3) != 0);
         h = $urandom_range(1, 4);
         len = $urandom_range(1, 14);
         pk.delete();
         for (int i = 0; i < len; i++) pk.push_back(8'($urandom));
         send_pkt(h, pk, 1'b1);
      end
      rand_rdy = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/axi_stream_strip_header.md
Name: axi_stream_strip_header

Overview:
Downstream counterpart of the header-insert stage. Per packet, removes a configurable number of leading header bytes (1..DATA_BYTE_WD) from an AXI-Stream, emits them on a separate header port, and re-aligns the remaining payload so that its first byte lands in the MSB lane. Byte order is big-endian: byte lane DATA_BYTE_WD-1 (the MSB) is the first byte on the wire. All keep masks are contiguous and MSB-aligned.

Parameters:
DATA_WD, 32, stream data width in bits.
DATA_BYTE_WD, DATA_WD/8, bytes per beat.
BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the strip-count field.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
valid_in  in  1  input beat valid.
data_in  in  DATA_WD  input data.
keep_in  in  DATA_BYTE_WD  input byte enables; all ones except on the last beat.
last_in  in  1  last beat of packet.
ready_in  out  1  input ready.
valid_out  out  1  payload beat valid.
data_out  out  DATA_WD  realigned payload.
keep_out  out  DATA_BYTE_WD  payload byte enables.
last_out  out  1  last payload beat.
ready_out  in  1  downstream ready.
valid_strip  in  1  strip-config valid, one per packet.
byte_strip_cnt  in  BYTE_CNT_WD  header length minus 1 (H = cnt+1 bytes).
ready_strip  out  1  config ready.
valid_hdr  out  1  header valid.
data_hdr  out  DATA_WD  header bytes, MSB-aligned, unused lanes zero.
keep_hdr  out  DATA_BYTE_WD  header byte enables.
ready_hdr  in  1  header consumer ready.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. valid_out, valid_hdr, last_out, ready_in and ready_strip are 0; data/keep outputs are 0; the hold register is cleared. A reset mid-packet discards the packet; there is no partial flush.
- The transfer rule on every port is valid&&ready at a rising edge. Once a valid output is asserted, it and its data stay stable until accepted.
- Output regs: one payload register and one header register, each single-entry. A register may load when it is empty or being drained in the same cycle.
- IDLE: ready_strip=1 and ready_in=0. A config handshake latches S=H=cnt+1 and moves to FIRST.
- FIRST: ready_in=1 when the header reg can load and the payload reg can load. On the beat handshake, with k = popcount(keep_in):
  - The header reg takes the top min(H,k) bytes; keep_hdr has min(H,k) ones from the MSB.
  - The hold reg takes the remaining P = DATA_BYTE_WD-H bytes.
  - If last_in: when k>H, emit one payload beat holding the top k-H bytes with last_out=1. When k<=H, emit no payload beat. Then return to IDLE.
  - Otherwise go to STREAM. For H=DATA_BYTE_WD the hold reg is empty and payload passes through aligned.
- STREAM: ready_in=1 when the payload reg can load. Each beat, with k valid bytes, outputs {hold P bytes, top min(S,k) bytes of data_in}; the low DATA_BYTE_WD-S bytes of the beat are moved into the hold reg.
  - Last beat with k<=S: output keep = P+k ones, last_out=1, go to IDLE.
  - Last beat with k>S: output a full beat with last_out=0, then go to FLUSH with k-S bytes held.
- FLUSH: ready_in=0. Emit the held bytes MSB-aligned with last_out=1, then go to IDLE. No config is accepted until the flush beat is loaded.
- Latency: 1 cycle from input accept to valid_out/valid_hdr when there is no backpressure. Sustained throughput is 1 beat/cycle in STREAM. A FLUSH costs one extra beat per packet.
- Unused output lanes are driven to zero.
- Simultaneous events: the header and payload regs drain independently. A stalled ready_hdr does not block STREAM but does block the next FIRST.
- Width rules: the shift amount is computed in bytes times 8. popcount is over DATA_BYTE_WD bits. Keep masks are generated as ~({DATA_BYTE_WD{1}} >> n).

Decomposition:
- Shared package axi_stream_pkg: state enum (IDLE/FIRST/STREAM/FLUSH), keep-from-count and popcount functions, and the byte-lane shift helper. The insert-header stage shares the package.
- One sub-module, axi_stream_out_reg: single-entry valid/ready register with data, keep and last. It is instantiated for payload and for header (last tied 0).

Test Plan:
1. H=2 (cnt=1), beats 0xAABBCCDD/1111, then 0x11223344/1111 last -> hdr 0xAABB0000/1100; out 0xCCDD1122/1111 last=0, then 0x33440000/1100 last=1.
2. H=1, single beat 0xAABBCC00/1110 last -> hdr 0xAA000000/1000; out 0xBBCC0000/1100 last=1.
3. H=4, beats 0xDEADBEEF, 0x01020304, 0x05060000/1100 last -> hdr 0xDEADBEEF/1111; out 0x01020304/1111, then 0x05060000/1100 last=1 with no flush beat.
4. H=3, single beat 0xAABBCC00/1110 last -> hdr 0xAABBCC00/1110; no payload beat; ready_strip=1 on the next cycle.
5. As in case 1 but ready_out toggles 0/1 randomly and ready_hdr=0 for 5 cycles -> payload is bit-identical and in order; valid_out/data_out are stable while stalled; the next packet's FIRST is held until the header drains.
6. Assert rst for 1 cycle mid-STREAM -> the next cycle has valid_out=0, valid_hdr=0, ready_strip=1; a following packet is processed cleanly.
